// File: rtl/wave_capture_sched.sv
// Zero-crossing triggered capture into the hidden half of a double-buffered wave RAM.
// Optional AUTO_TRIG_EN: forces a trigger after AUTO_TRIG_SAMPLES quiet samples in ARMED.
module wave_capture_sched #(
  parameter int unsigned ADDR_W            = 8,
  parameter int unsigned DECIM             = 1,
  parameter int unsigned AUTO_TRIG_SAMPLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_sample_ready,
  input  logic [7:0]        new_sample,
  input  logic              wave_display_idle,
  output logic              write_enable,
  output logic [ADDR_W:0]   write_address,
  output logic [7:0]        write_sample,
  output logic              read_index,
  output logic              frame_done,
  output logic [1:0]        capture_state
);

  typedef enum logic [1:0] {
    ARMED  = 2'b00,
    ACTIVE = 2'b01,
    WAIT   = 2'b10
  } state_t;

  localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);

  state_t            state;
  logic [7:0]        prev;
  logic [ADDR_W-1:0] count;
  logic [DW-1:0]     dec_cnt;
  logic [7:0]        fmt;
  logic              crossing;
  logic              trigger;
  logic              unused_lsb;

  // Offset-binary, halved: the display wants 0..127 with silence at 0x40.
  assign fmt        = {1'b0, ~new_sample[7], new_sample[6:1]};
  assign unused_lsb = new_sample[0];
  assign crossing   = prev[7] & ~new_sample[7];

`ifdef AUTO_TRIG_EN
  localparam int unsigned AT_W = $clog2(AUTO_TRIG_SAMPLES + 1);
  localparam logic [AT_W-1:0] AT_LIMIT = AT_W'(AUTO_TRIG_SAMPLES);
  logic [AT_W-1:0] quiet_cnt;
  assign trigger = crossing | (quiet_cnt == AT_LIMIT);
`else
  localparam int unsigned AUTO_UNUSED = AUTO_TRIG_SAMPLES;
  assign trigger = crossing;
`endif

  assign capture_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ARMED;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
      frame_done    <= 1'b0;
      prev          <= 8'h00;
      count         <= '0;
      dec_cnt       <= '0;
`ifdef AUTO_TRIG_EN
      quiet_cnt     <= '0;
`endif
    end else begin
      write_enable <= 1'b0;
      frame_done   <= 1'b0;
      unique case (state)
        ARMED: begin
          if (new_sample_ready) begin
            prev <= new_sample;
            if (trigger) begin
              write_enable  <= 1'b1;
              write_address <= {~read_index, {ADDR_W{1'b0}}};
              write_sample  <= fmt;
              count         <= ADDR_W'(1);
              dec_cnt       <= '0;
              state         <= ACTIVE;
`ifdef AUTO_TRIG_EN
              quiet_cnt     <= '0;
            end else begin
              quiet_cnt     <= quiet_cnt + 1'b1;
`endif
            end
          end
        end
        ACTIVE: begin
          if (new_sample_ready) begin
            if (dec_cnt == DEC_LAST) begin
              dec_cnt       <= '0;
              write_enable  <= 1'b1;
              write_address <= {~read_index, count};
              write_sample  <= fmt;
              if (count == '1) begin
                count <= '0;
                state <= WAIT;
              end else begin
                count <= count + 1'b1;
              end
            end else begin
              dec_cnt <= dec_cnt + 1'b1;
            end
          end
        end
        WAIT: begin
          if (wave_display_idle) begin
            read_index <= ~read_index;
            frame_done <= 1'b1;
            prev       <= 8'h00;
            state      <= ARMED;
`ifdef AUTO_TRIG_EN
            quiet_cnt  <= '0;
`endif
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture_sched.sv
// Random and directed bench for wave_capture_sched; DECIM=1 and DECIM=4 instances share stimulus.
module tb_wave_capture_sched;

  localparam int NUM  = 256;
  localparam int AUTO = 1024;

  logic       clk = 1'b0;
  logic       reset, rdy, idle;
  logic [7:0] s;
  logic       we [2];
  logic       ri [2];
  logic       fd [2];
  logic [8:0] wa [2];
  logic [7:0] ws [2];
  logic [1:0] cs [2];

  int checks = 0;
  int errors = 0;
  int decim [2] = '{1, 4};
  int wr_cnt [2] = '{0, 0};

  // reference model: mode 0 armed, 1 capturing, 2 holding for flip
  int m_mode [2], m_prev [2], m_k [2], m_stored [2], m_quiet [2];
  int m_wa [2], m_ws [2];
  bit m_we [2], m_fd [2], m_ri [2];

  always #5 clk = ~clk;

  wave_capture_sched #(.ADDR_W(8), .DECIM(1), .AUTO_TRIG_SAMPLES(AUTO)) dut0 (
    .clk(clk), .reset(reset), .new_sample_ready(rdy), .new_sample(s),
    .wave_display_idle(idle), .write_enable(we[0]), .write_address(wa[0]),
    .write_sample(ws[0]), .read_index(ri[0]), .frame_done(fd[0]), .capture_state(cs[0]));

  wave_capture_sched #(.ADDR_W(8), .DECIM(4), .AUTO_TRIG_SAMPLES(AUTO)) dut1 (
    .clk(clk), .reset(reset), .new_sample_ready(rdy), .new_sample(s),
    .wave_display_idle(idle), .write_enable(we[1]), .write_address(wa[1]),
    .write_sample(ws[1]), .read_index(ri[1]), .frame_done(fd[1]), .capture_state(cs[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic emit(input int m, input int entry);
    m_we[m] = 1'b1;
    m_wa[m] = (m_ri[m] ? 0 : NUM) + entry;
    m_ws[m] = (int'($signed(s)) + 128) / 2;
  endtask

  task automatic model_step(input int m);
    bit trig;
    m_we[m] = 1'b0;
    m_fd[m] = 1'b0;
    if (!reset) begin
      m_mode[m] = 0; m_ri[m] = 1'b0; m_wa[m] = 0; m_ws[m] = 0;
      m_prev[m] = 0; m_k[m] = 0; m_stored[m] = 0; m_quiet[m] = 0;
      return;
    end
    case (m_mode[m])
      0: if (rdy) begin
        trig = (m_prev[m] < 0) && (int'($signed(s)) >= 0);
`ifdef AUTO_TRIG_EN
        if (m_quiet[m] == AUTO) trig = 1'b1;
`endif
        m_prev[m] = int'($signed(s));
        if (trig) begin
          emit(m, 0);
          m_stored[m] = 1; m_k[m] = 0; m_mode[m] = 1; m_quiet[m] = 0;
        end else begin
          m_quiet[m]++;
        end
      end
      1: if (rdy) begin
        m_k[m]++;
        if (m_k[m] % decim[m] == 0) begin
          emit(m, m_stored[m]);
          m_stored[m]++;
          if (m_stored[m] == NUM) m_mode[m] = 2;
        end
      end
      default: if (idle) begin
        m_ri[m] = ~m_ri[m]; m_fd[m] = 1'b1; m_prev[m] = 0; m_mode[m] = 0; m_quiet[m] = 0;
      end
    endcase
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic i);
    reset = r; rdy = v; s = d; idle = i;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("d%0d_state", m), 32'(cs[m]), 32'(m_mode[m]));
      check($sformatf("d%0d_ri", m), 32'(ri[m]), 32'(m_ri[m]));
      check($sformatf("d%0d_we", m), 32'(we[m]), 32'(m_we[m]));
      check($sformatf("d%0d_fd", m), 32'(fd[m]), 32'(m_fd[m]));
      check($sformatf("d%0d_wa", m), 32'(wa[m]), 32'(m_wa[m]));
      check($sformatf("d%0d_ws", m), 32'(ws[m]), 32'(m_ws[m]));
      if (we[m] === 1'b1) wr_cnt[m]++;
    end
  endtask

  task automatic strobe(input logic [7:0] d);
    cyc(1'b1, 1'b1, d, 1'b0);
  endtask

  int first_wr;

  initial begin
    // reset, some traffic, then reset held mid-stream
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b1);
    check("rst_state", 32'(cs[0]), 0);
    check("rst_wa", 32'(wa[0]), 0);
    check("rst_ri", 32'(ri[0]), 0);

    // trigger on a rising crossing
    strobe(8'h90);
    check("pre_trig_we", 32'(we[0]), 0);
    strobe(8'h10);
    check("trig_we", 32'(we[0]), 1);
    check("trig_wa", 32'(wa[0]), 32'h100);
    check("trig_ws", 32'(ws[0]), 32'h48);
    check("trig_state", 32'(cs[0]), 1);

    // fill the frame back-to-back, then samples in WAIT are dropped
    wr_cnt[0] = 0;
    for (int i = 0; i < 255; i++) strobe(8'($urandom));
    check("fill_writes", 32'(wr_cnt[0]), 255);
    check("fill_last_wa", 32'(wa[0]), 32'h1FF);
    check("fill_state", 32'(cs[0]), 2);
    wr_cnt[0] = 0;
    for (int i = 0; i < 10; i++) strobe(8'($urandom));
    check("wait_writes", 32'(wr_cnt[0]), 0);

    // flip with a simultaneous strobe
    cyc(1'b1, 1'b1, 8'h85, 1'b1);
    check("flip_ri", 32'(ri[0]), 1);
    check("flip_fd", 32'(fd[0]), 1);
    check("flip_state", 32'(cs[0]), 0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("flip_fd_pulse", 32'(fd[0]), 0);
    strobe(8'hF0);
    strobe(8'h00);
    check("cap2_wa0", 32'(wa[0]), 32'h000);
    check("cap2_ws0", 32'(ws[0]), 32'h40);
    for (int i = 0; i < 255; i++) strobe(8'($urandom));
    check("cap2_last_wa", 32'(wa[0]), 32'h0FF);

    // decimation by 4, then abort by reset
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    strobe(8'h80);
    strobe(8'h7F);
    check("dec_trig_ws", 32'(ws[1]), 32'h7F);
    wr_cnt[1] = 0;
    for (int i = 0; i < 12; i++) strobe(8'($urandom));
    check("dec_writes", 32'(wr_cnt[1]), 3);
    check("dec_last_wa", 32'(wa[1]), 32'h103);
    cyc(1'b0, 1'b1, 8'h10, 1'b1);
    check("abort_state", 32'(cs[1]), 0);
    check("abort_ri", 32'(ri[1]), 0);
    check("abort_fd", 32'(fd[1]), 0);

    // constant positive input: only the forced trigger can fire
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    wr_cnt[0] = 0;
    first_wr = 0;
    for (int i = 1; i <= 2000; i++) begin
      strobe(8'h20);
      if (we[0] === 1'b1 && first_wr == 0) begin
        first_wr = i;
        check("auto_wa", 32'(wa[0]), 32'h100);
        check("auto_ws", 32'(ws[0]), 32'h50);
      end
    end
`ifdef AUTO_TRIG_EN
    check("auto_first", 32'(first_wr), AUTO + 1);
`else
    check("no_cross_writes", 32'(wr_cnt[0]), 0);
`endif

    // random traffic with rare resets
    for (int i = 0; i < 20000; i++)
      cyc(($urandom_range(1999) != 0), ($urandom_range(9) < 7), 8'($urandom),
          ($urandom_range(19) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_capture_sched.md
Name: wave_capture_sched

Overview:
Capture controller for the 512-entry double-buffered waveform RAM read by the wave display. It watches the incoming audio sample stream and arms on a rising zero crossing. It then writes one 256-sample frame into the half of the RAM that is not being displayed. When the display reports it is idle, it flips `read_index` so the new frame is shown tear-free.

Parameters:
ADDR_W, 8, per-half address width; frame length NUM = 2**ADDR_W samples.
DECIM, 1, store every DECIM-th accepted sample while ACTIVE (DECIM >= 1).
AUTO_TRIG_SAMPLES, 1024, forced-trigger threshold; used only with AUTO_TRIG_EN.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
new_sample_ready  in  1  one-cycle strobe; new_sample valid this cycle
new_sample  in  8  signed two's-complement audio sample
wave_display_idle  in  1  high while the display is not reading the RAM (vblank)
write_enable  out  1  RAM write strobe
write_address  out  ADDR_W+1  {~read_index, entry index}
write_sample  out  8  display-format sample
read_index  out  1  RAM half the display reads
frame_done  out  1  one-cycle pulse on buffer flip
capture_state  out  2  current state: 00 ARMED, 01 ACTIVE, 10 WAIT

Behaviour:
- Reset, sampled on posedge clk with reset==0:
  - state ARMED; read_index 0.
  - write_enable 0, write_address 0, write_sample 0, frame_done 0.
  - prev sample 8'h00; entry count 0; decimation count 0.
- All outputs are registered. A write produced by a sample accepted in cycle N appears as write_enable=1 in cycle N+1, for exactly one cycle.
- Sample format: write_sample = {1'b0, ~s[7], s[6:1]}, where s = new_sample. So 0 maps to 0x40, -128 to 0x00, +127 to 0x7F.
- ARMED:
  - On each new_sample_ready, trigger if prev[7]==1 and new_sample[7]==0; then update prev to new_sample.
  - On trigger: the triggering sample is written as entry 0, count becomes 1, decimation count resets to 0, and the next state is ACTIVE.
- ACTIVE:
  - Each new_sample_ready advances the decimation counter (0..DECIM-1, wraps).
  - A sample is stored only when the counter equals DECIM-1. It is written at entry = count, and count increments.
  - After entry NUM-1 is written, go to WAIT; count returns to 0.
- WAIT:
  - All samples are dropped; write_enable stays 0.
  - On wave_display_idle==1: read_index toggles, frame_done pulses for one cycle (same edge), prev clears to 8'h00, and the next state is ARMED.
  - new_sample_ready and wave_display_idle in the same WAIT cycle: the sample is dropped and the flip proceeds.
- wave_display_idle is ignored outside WAIT. write_address MSB is always ~read_index, so the displayed half is never written.
- Count width is ADDR_W; wrap-around is impossible because the transition to WAIT occurs at NUM-1.
- Reset asserted mid-ACTIVE or mid-WAIT aborts the frame:
  - The partially written half is discarded; no flip and no frame_done.
  - All reset values apply on the next edge.
- Back-to-back strobes (every cycle) must be handled without loss in ARMED and ACTIVE.

Optional Feature:
Macro AUTO_TRIG_EN.
- Defined: in ARMED, a counter counts samples examined without a trigger, and clears on entering ARMED.
  - When it reaches AUTO_TRIG_SAMPLES, the next sample is treated as a trigger regardless of sign.
  - This keeps the display updating for DC or silent input.
- Undefined: no counter exists, and ARMED waits indefinitely for a zero crossing.

Test Plan:
1. Reset: hold reset=0 for 3 cycles mid-stream -> capture_state=00, read_index=0, write_enable=0, write_address=0, frame_done=0.
2. Trigger: strobe 0x90, then 0x10 -> the cycle after the 0x10 strobe shows write_enable=1, write_address=0x100, write_sample=0x48, capture_state=01. The 0x90 strobe produces no write.
3. Fill: after the trigger, 255 more strobes at one per cycle -> addresses 0x101..0x1FF in order, then capture_state=10. A further 10 strobes produce no write_enable.
4. Flip: in WAIT, assert wave_display_idle with a simultaneous strobe -> next edge shows read_index=1, a single-cycle frame_done, capture_state=00. The next capture writes 0x000..0x0FF.
5. Decimation and abort:
   - DECIM=4, trigger, then 12 strobes -> exactly 3 writes, at entries 1, 2, 3.
   - Then reset=0 for 1 cycle -> capture_state=00, read_index unchanged at 0, no frame_done.
6. No crossing: 2000 strobes of 0x20.
   - Without AUTO_TRIG_EN -> no writes.
   - With AUTO_TRIG_EN and AUTO_TRIG_SAMPLES=1024 -> the 1025th strobe is written at 0x100 with data 0x50.
